// File: rtl/items_pkg.sv
// Shared types and constants for the items_ram arbiter.
// Holds RAM geometry, the background color, pellet total and FSM states.
package items_pkg;

    localparam int ADDR_W         = 12;
    localparam int DATA_W         = 24;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int STARVE_MAX_DEF = 64;
    localparam int TOTAL_PELLETS  = 244;

    localparam logic [DATA_W-1:0] BG_COLOR = 24'h000000;

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        CHK
    } arb_state_t;

endpackage

// File: rtl/items_erase_fifo.sv
// Small erase-request queue: DEPTH entries of W-bit addresses.
// Ports: clk_i, rst_ni, push_i/data_i, pop_i, head_o, full_o, empty_o.
module items_erase_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   cnt_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the slot the push needs, so both may fire when full.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/items_ram_arbiter.sv
// Shares the items_ram read port between video fetch and pellet erases
// (read-modify-write). Ports: Clk/Reset_n, video read, erase handshake,
// pellet counter, and the items_ram read/write port signals.
module items_ram_arbiter
    import items_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              vid_rd_en,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    output logic              vid_stale,
    input  logic              erase_valid,
    input  logic [ADDR_W-1:0] erase_addr,
    output logic              erase_ready,
    input  logic              count_clr,
    output logic [ADDR_W-1:0] pellets_eaten,
    output logic              all_eaten,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_data_in
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_t        state_q;
    logic [SW-1:0]     starve_q;
    logic              we_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              all_q;
    logic              vid_valid_q;
    logic              vid_stale_q;
    logic [DATA_W-1:0] held_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [ADDR_W-1:0] head;
    logic              erase_slot;

    items_erase_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ADDR_W)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_ni  (Reset_n),
        .push_i  (erase_valid && erase_ready),
        .data_i  (erase_addr),
        .pop_i   (fifo_pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Video wins unless it is idle or the erase has waited long enough.
    assign erase_slot = (state_q == RD_REQ)
                     && (!vid_rd_en || starve_q == SW'(STARVE_MAX));

    assign fifo_pop      = (state_q == CHK);
    assign erase_ready   = !fifo_full;
    assign ram_rd_addr   = erase_slot ? head : vid_addr;
    assign ram_we        = we_q;
    assign ram_wr_addr   = wr_addr_q;
    assign ram_data_in   = BG_COLOR;
    assign pellets_eaten = cnt_q;
    assign all_eaten     = all_q;
    assign vid_valid     = vid_valid_q;
    assign vid_stale     = vid_stale_q;

    // A stolen slot replays the last real pixel instead of erase data.
    always_comb begin
        vid_data = '0;
        if (vid_stale_q) begin
            vid_data = held_q;
        end else if (vid_valid_q) begin
            vid_data = ram_data_out;
        end
    end

    // RD_WAIT sees the erase read data; the write decision is registered
    // there so ram_we is a clean flop output during CHK.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            we_q      <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (erase_slot) begin
                        starve_q <= '0;
                        state_q  <= RD_WAIT;
                    end else if (starve_q != SW'(STARVE_MAX)) begin
                        starve_q <= starve_q + 1'b1;
                    end
                end
                RD_WAIT: begin
                    we_q      <= (ram_data_out != BG_COLOR);
                    wr_addr_q <= head;
                    state_q   <= CHK;
                end
                CHK: begin
                    we_q    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Clear has priority over a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        if (count_clr) begin
            cnt_d = '0;
        end else if (state_q == CHK && we_q && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= '0;
            all_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            all_q <= (cnt_q >= ADDR_W'(TOTAL_PELLETS));
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vid_valid_q <= 1'b0;
            vid_stale_q <= 1'b0;
            held_q      <= '0;
        end else begin
            vid_valid_q <= vid_rd_en;
            vid_stale_q <= vid_rd_en && erase_slot;
            if (vid_valid_q && !vid_stale_q) begin
                held_q <= ram_data_out;
            end
        end
    end

endmodule

// File: tb/tb_items_ram_arbiter.sv
// Bench for items_ram_arbiter: behavioural items_ram plus random video
// traffic, directed erase scenarios and a pellet-count reference model.
module tb_items_ram_arbiter;
    import items_pkg::*;

    localparam int SMAX = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              vid_rd_en = 1'b0;
    logic [ADDR_W-1:0] vid_addr = '0;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;
    logic              vid_stale;
    logic              erase_valid = 1'b0;
    logic [ADDR_W-1:0] erase_addr = '0;
    logic              erase_ready;
    logic              count_clr = 1'b0;
    logic [ADDR_W-1:0] pellets_eaten;
    logic              all_eaten;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_data_out;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_data_in;

    logic [DATA_W-1:0] mem [4096];
    logic              fill_en = 1'b0;
    logic [ADDR_W-1:0] fill_addr = '0;
    logic [DATA_W-1:0] fill_data = '0;
    bit                seen [4096];

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int stale_cnt = 0;
    int vid_mode = 0;

    logic              exp_v = 1'b0;
    logic [DATA_W-1:0] exp_pix = '0;
    logic [DATA_W-1:0] last_good = '0;

    always #5 clk = ~clk;

    items_ram_arbiter #(
        .FIFO_DEPTH (4),
        .STARVE_MAX (SMAX)
    ) dut (
        .Clk           (clk),
        .Reset_n       (rst_n),
        .vid_rd_en     (vid_rd_en),
        .vid_addr      (vid_addr),
        .vid_data      (vid_data),
        .vid_valid     (vid_valid),
        .vid_stale     (vid_stale),
        .erase_valid   (erase_valid),
        .erase_addr    (erase_addr),
        .erase_ready   (erase_ready),
        .count_clr     (count_clr),
        .pellets_eaten (pellets_eaten),
        .all_eaten     (all_eaten),
        .ram_rd_addr   (ram_rd_addr),
        .ram_data_out  (ram_data_out),
        .ram_we        (ram_we),
        .ram_wr_addr   (ram_wr_addr),
        .ram_data_in   (ram_data_in)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // items_ram: registered read, old data on same-address read/write.
    always @(posedge clk) begin
        ram_data_out <= mem[ram_rd_addr];
        if (fill_en) mem[fill_addr] <= fill_data;
        if (ram_we) mem[ram_wr_addr] <= ram_data_in;
        if (ram_we) wr_cnt <= wr_cnt + 1;
    end

    always @(negedge clk) begin
        case (vid_mode)
            0:       vid_rd_en = 1'b0;
            1:       vid_rd_en = 1'b1;
            default: vid_rd_en = 1'($urandom_range(1));
        endcase
        vid_addr = ADDR_W'($urandom_range(2047));
    end

    // Video expectation: the cell's value at request time, one cycle later.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_v <= 1'b0;
        end else begin
            exp_v   <= vid_rd_en;
            exp_pix <= mem[vid_addr];
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            last_good <= '0;
        end else begin
            check("vid_valid", 32'(vid_valid), 32'(exp_v));
            if (exp_v && !vid_stale) begin
                check("vid_data", 32'(vid_data), 32'(exp_pix));
                last_good <= exp_pix;
            end else if (exp_v) begin
                check("vid_stale_data", 32'(vid_data), 32'(last_good));
                stale_cnt <= stale_cnt + 1;
            end else begin
                check("vid_stale_idle", 32'(vid_stale), 32'd0);
            end
        end
    end

    task automatic fill(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        fill_en = 1'b1;
        fill_addr = a;
        fill_data = d;
        @(negedge clk);
        fill_en = 1'b0;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a);
        int t = 0;
        @(negedge clk);
        while (!erase_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("push_ready", 32'(erase_ready), 32'd1);
        erase_valid = 1'b1;
        erase_addr = a;
        @(posedge clk);
        #1 erase_valid = 1'b0;
    endtask

    task automatic wait_we(input int max, output int lat);
        lat = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (ram_we) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, wc, sc, exp_cnt, guard, bad, t;
        logic [ADDR_W-1:0] a;

        // T1: reset held with random inputs while the RAM is filled.
        vid_mode = 2;
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            fill_en = 1'b1;
            fill_addr = ADDR_W'(i);
            fill_data = ($urandom_range(3) == 0) ? '0 :
                        DATA_W'($urandom_range(24'hFFFFFF, 1));
            erase_valid = 1'($urandom_range(1));
            erase_addr = ADDR_W'($urandom);
            count_clr = 1'($urandom_range(1));
            if (i % 256 == 255) begin
                check("rst_vid_valid", 32'(vid_valid), 32'd0);
                check("rst_vid_stale", 32'(vid_stale), 32'd0);
                check("rst_vid_data", 32'(vid_data), 32'd0);
                check("rst_ram_we", 32'(ram_we), 32'd0);
                check("rst_erase_ready", 32'(erase_ready), 32'd1);
                check("rst_pellets", 32'(pellets_eaten), 32'd0);
                check("rst_all_eaten", 32'(all_eaten), 32'd0);
            end
        end
        @(negedge clk);
        fill_en = 1'b0;
        erase_valid = 1'b0;
        count_clr = 1'b0;
        fill(12'h05A, 24'hABCDEF);
        fill(12'h100, 24'h000000);
        fill(12'h200, 24'h123456);
        for (int i = 0; i < 4; i++) fill(ADDR_W'(12'h300 + i), 24'h00A000 + DATA_W'(i));
        fill(12'h051, 24'h000F0F);
        vid_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // T2: idle video, pellet cell.
        push(12'h05A);
        wait_we(20, lat);
        check("t2_latency", 32'(lat), 32'd3);
        check("t2_wr_addr", 32'(ram_wr_addr), 32'h05A);
        check("t2_wr_data", 32'(ram_data_in), 32'(BG_COLOR));
        repeat (2) @(negedge clk);
        check("t2_pellets", 32'(pellets_eaten), 32'd1);
        check("t2_cell", 32'(mem[12'h05A]), 32'(BG_COLOR));
        check("t2_all_eaten", 32'(all_eaten), 32'd0);

        // T3: cell already background.
        wc = wr_cnt;
        push(12'h100);
        repeat (8) @(negedge clk);
        check("t3_no_write", 32'(wr_cnt - wc), 32'd0);
        check("t3_pellets", 32'(pellets_eaten), 32'd1);
        check("t3_ready", 32'(erase_ready), 32'd1);

        // T4: continuous video forces one stolen slot.
        vid_mode = 1;
        repeat (3) @(negedge clk);
        sc = stale_cnt;
        push(12'h200);
        wait_we(300, lat);
        check("t4_latency", 32'(lat), 32'(3 + SMAX));
        repeat (4) @(negedge clk);
        check("t4_stale_pulses", 32'(stale_cnt - sc), 32'd1);
        check("t4_pellets", 32'(pellets_eaten), 32'd2);
        check("t4_cell", 32'(mem[12'h200]), 32'(BG_COLOR));

        // T5: fill the queue during video, with a duplicate address.
        wc = wr_cnt;
        sc = stale_cnt;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t5_ready_pre", 32'(erase_ready), 32'd1);
            erase_valid = 1'b1;
            erase_addr = (k == 3) ? 12'h300 : ADDR_W'(12'h300 + k);
            @(posedge clk);
        end
        @(negedge clk);
        check("t5_full", 32'(erase_ready), 32'd0);
        erase_addr = 12'h303;
        t = 0;
        while (!erase_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("t5_ready_after_pop", 32'(wr_cnt - wc), 32'd1);
        @(posedge clk);
        #1 erase_valid = 1'b0;
        t = 0;
        while (wr_cnt - wc < 4 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        check("t5_writes", 32'(wr_cnt - wc), 32'd4);
        check("t5_pellets", 32'(pellets_eaten), 32'd6);
        check("t5_stale_pulses", 32'(stale_cnt - sc), 32'd5);
        check("t5_ready_end", 32'(erase_ready), 32'd1);

        // Level restart.
        vid_mode = 0;
        @(negedge clk);
        count_clr = 1'b1;
        @(negedge clk);
        count_clr = 1'b0;
        check("clr_pellets", 32'(pellets_eaten), 32'd0);
        @(negedge clk);
        check("clr_all_eaten", 32'(all_eaten), 32'd0);

        // T6: random erases against a distinct-cell pellet model.
        vid_mode = 2;
        for (int i = 0; i < 4096; i++) seen[i] = 1'b0;
        exp_cnt = 0;
        guard = 0;
        while (exp_cnt < 250 && guard < 3000) begin
            a = 12'h400 + ADDR_W'($urandom_range(1023));
            if (!seen[a] && mem[a] != BG_COLOR) exp_cnt++;
            seen[a] = 1'b1;
            push(a);
            repeat ($urandom_range(2)) @(negedge clk);
            guard++;
        end
        repeat (400) @(negedge clk);
        check("t6_pellets", 32'(pellets_eaten), 32'(exp_cnt));
        check("t6_all_eaten", 32'(all_eaten), 32'd1);
        bad = 0;
        for (int i = 0; i < 4096; i++) begin
            if (seen[i] && mem[i] != BG_COLOR) bad++;
        end
        check("t6_cells_cleared", 32'(bad), 32'd0);

        // count_clr in the same cycle as a counted write.
        vid_mode = 0;
        fill(12'h052, 24'h5A5A5A);
        push(12'h052);
        wait_we(20, lat);
        check("clr_chk_latency", 32'(lat), 32'd3);
        count_clr = 1'b1;
        @(negedge clk);
        count_clr = 1'b0;
        check("clr_wins", 32'(pellets_eaten), 32'd0);
        check("all_eaten_lag", 32'(all_eaten), 32'd1);
        @(negedge clk);
        check("all_eaten_drop", 32'(all_eaten), 32'd0);

        // Counter saturation: refill one cell and erase it repeatedly.
        bad = 0;
        for (int k = 0; k < 4097; k++) begin
            @(negedge clk);
            fill_en = 1'b1;
            fill_addr = 12'h050;
            fill_data = 24'h00FF00;
            erase_valid = 1'b1;
            erase_addr = 12'h050;
            @(posedge clk);
            #1;
            fill_en = 1'b0;
            erase_valid = 1'b0;
            wait_we(12, lat);
            if (lat != 3) bad++;
        end
        repeat (3) @(negedge clk);
        check("sat_latency_bad", 32'(bad), 32'd0);
        check("sat_pellets", 32'(pellets_eaten), 32'hFFF);
        check("sat_all_eaten", 32'(all_eaten), 32'd1);

        // Reset asserted while the erase is in RD_WAIT.
        wc = wr_cnt;
        push(12'h051);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_mid_we", 32'(ram_we), 32'd0);
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_mid_no_write", 32'(wr_cnt - wc), 32'd0);
        check("rst_mid_cell", 32'(mem[12'h051]), 32'h000F0F);
        check("rst_mid_pellets", 32'(pellets_eaten), 32'd0);
        check("rst_mid_ready", 32'(erase_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
